mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU on two N-bit operands and produces the HI/LO result pair. It sits directly upstream of the HI and LO registers: its `HiLoWrite` pulse drives their `enable` inputs, and `HiOut`/`LoOut` drive their `DataInput` ports. It uses a shift-add/shift-subtract datapath with one result bit per cycle.

---
 rtl/mult_div_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) feeding
//            the HI/LO registers. Shift-add multiply and restoring
//            shift-subtract divide, one result bit per clock.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset
//            Start      - operation request, sampled in IDLE only
//            Operation  - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            OperandA   - multiplicand / dividend (rs)
//            OperandB   - multiplier / divisor (rt)
//            Busy       - operation in flight
//            HiLoWrite  - one-cycle pulse, HiOut/LoOut valid
//            HiOut      - high product half / remainder
//            LoOut      - low product half / quotient
// Config   : MULT_DIV_SIGNED_EN - when defined, MULT/DIV use signed
//            magnitude conversion and sign correction; otherwise they
//            behave as MULTU/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Start,
   input  logic [1:0]   Operation,
   input  logic [N-1:0] OperandA,
   input  logic [N-1:0] OperandB,
   output logic         Busy,
   output logic         HiLoWrite,
   output logic [N-1:0] HiOut,
   output logic [N-1:0] LoOut
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_RUN    = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam int             CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           is_div_q, is_div_d;
   logic [N-1:0]   a_q, a_d;          // raw operand, then magnitude after LOAD
   logic [N-1:0]   b_q, b_d;
   logic [2*N-1:0] acc_q, acc_d;      // product, or remainder:quotient
   logic           busy_q, busy_d;
   logic           hlw_q, hlw_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;

`ifdef MULT_DIV_SIGNED_EN
   logic           sign_a_q, sign_a_d;
   logic           sign_b_q, sign_b_d;
`else
   // The signedness bit of Operation has no meaning in this build.
   logic           unused_op_lsb;
   assign unused_op_lsb = Operation[0];
`endif

   // Datapath temporaries
   logic [N-1:0]   mag_a, mag_b;
   logic [N:0]     mul_sum;
   logic [N:0]     div_top;
   logic [N:0]     div_diff;
   logic [2*N-1:0] prod;
   logic [N-1:0]   quo, rem;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      hlw_d    = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef MULT_DIV_SIGNED_EN
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
`endif
      mag_a    = a_q;
      mag_b    = b_q;
      mul_sum  = '0;
      div_top  = '0;
      div_diff = '0;
      prod     = acc_q;
      quo      = acc_q[N-1:0];
      rem      = acc_q[2*N-1:N];

      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               a_d      = OperandA;
               b_d      = OperandB;
               is_div_d = Operation[1];
`ifdef MULT_DIV_SIGNED_EN
               sign_a_d = ~Operation[0] & OperandA[N-1];
               sign_b_d = ~Operation[0] & OperandB[N-1];
`endif
               busy_d   = 1'b1;
               state_d  = S_LOAD;
            end
         end

         S_LOAD: begin
`ifdef MULT_DIV_SIGNED_EN
            mag_a = sign_a_q ? -a_q : a_q;
            mag_b = sign_b_q ? -b_q : b_q;
`endif
            a_d   = mag_a;
            b_d   = mag_b;
            // Upper (partial result) half starts cleared; the lower half holds
            // the multiplier bits to consume, or the dividend bits to shift in.
            acc_d = is_div_q ? {{N{1'b0}}, mag_a} : {{N{1'b0}}, mag_b};
            cnt_d = '0;
            state_d = S_RUN;
         end

         S_RUN: begin
            if (!is_div_q) begin
               // Add into the upper half with a carry bit, then shift right;
               // the carry becomes the new MSB.
               mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
               acc_d   = {mul_sum, acc_q[N-1:1]};
            end else begin
               // Remainder after the left shift can need N+1 bits.
               div_top = acc_q[2*N-1:N-1];
               if (div_top >= {1'b0, b_q}) begin
                  div_diff = div_top - {1'b0, b_q};
                  acc_d    = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
               end else begin
                  acc_d    = {div_top[N-1:0], acc_q[N-2:0], 1'b0};
               end
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_FINISH;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end

         S_FINISH: begin
            if (!is_div_q) begin
`ifdef MULT_DIV_SIGNED_EN
               prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
`endif
               hi_d = prod[2*N-1:N];
               lo_d = prod[N-1:0];
            end else begin
`ifdef MULT_DIV_SIGNED_EN
               quo = (sign_a_q ^ sign_b_q) ? -acc_q[N-1:0] : acc_q[N-1:0];
               rem = sign_a_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
`endif
               // With a zero divisor every step subtracts zero, so the
               // remainder already equals OperandA; the quotient is forced so
               // its sign correction cannot disturb the all-ones value.
               hi_d = rem;
               lo_d = (b_q == '0) ? {N{1'b1}} : quo;
            end
            hlw_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         hlw_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MULT_DIV_SIGNED_EN
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         hlw_q    <= hlw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MULT_DIV_SIGNED_EN
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
`endif
      end
   end

   assign Busy      = busy_q;
   assign HiLoWrite = hlw_q;
   assign HiOut     = hi_q;
   assign LoOut     = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit (N = 32). Directed vector
//            table, hand-written multi-cycle corner sequences and random
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

   localparam int N       = 32;
   localparam int EXP_LAT = N + 2;

`ifdef MULT_DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic         clk = 1'b0;
   logic         reset;
   logic         Start;
   logic [1:0]   Operation;
   logic [N-1:0] OperandA;
   logic [N-1:0] OperandB;
   logic         Busy;
   logic         HiLoWrite;
   logic [N-1:0] HiOut;
   logic [N-1:0] LoOut;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
      .Operation (Operation),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .Busy      (Busy),
      .HiLoWrite (HiLoWrite),
      .HiOut     (HiOut),
      .LoOut     (LoOut)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] p;
      bit sgn;
      sgn = SIGNED_EN && (op[0] == 1'b0);
      sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      if (op[1] == 1'b0) begin
         p  = 64'(sa * sb);
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   // Issues one operation and waits for HiLoWrite. lat is the number of rising
   // edges after the accepting edge at which HiLoWrite was seen (-1 on timeout).
   // restart_at > 0 pulses Start with fresh operands during the run.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int restart_at,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
      @(negedge clk);
      Start = 1'b1; Operation = op; OperandA = a; OperandB = b;
      @(posedge clk); #1;
      check("busy_after_accept", {31'b0, Busy}, 32'd1);
      check("hlw_low_after_accept", {31'b0, HiLoWrite}, 32'd0);
      @(negedge clk);
      Start = 1'b0;
      Operation = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
      lat = -1;
      for (int k = 1; k <= EXP_LAT + 8; k++) begin
         @(posedge clk); #1;
         if (HiLoWrite) begin
            lat = k;
            break;
         end
         if (restart_at > 0 && k == restart_at) begin
            Start = 1'b1;
            Operation = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
         end else if (restart_at > 0 && k == restart_at + 1) begin
            Start = 1'b0;
         end
      end
      Start = 1'b0;
      hi = HiOut;
      lo = LoOut;
      if (lat > 0) check("busy_low_with_hlw", {31'b0, Busy}, 32'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] hi, lo, ehi, elo;
      int          lat, hlw_count;
      logic [1:0]  op;
      logic [31:0] a, b;

      vecs[0] = '{"multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
`ifdef MULT_DIV_SIGNED_EN
      vecs[1] = '{"mult_m3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{"div_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
`else
      vecs[1] = '{"mult_m3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB};
      vecs[2] = '{"div_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC};
      vecs[3] = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
`endif
      vecs[4] = '{"divu_by0",   OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
      vecs[5] = '{"div_neg_by0",OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6] = '{"divu_100d7", OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
      vecs[7] = '{"mult_minsq", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[8] = '{"multu_6x7",  OP_MULTU, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A};
      vecs[9] = '{"divu_small", OP_DIVU,  32'd5,         32'd9,         32'h0000_0005, 32'h0000_0000};

      reset = 1'b0; Start = 1'b0; Operation = 2'b00; OperandA = '0; OperandB = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, Busy}, 32'd0);
      check("reset_hlw",  {31'b0, HiLoWrite}, 32'd0);
      check("reset_hi",   HiOut, 32'd0);
      check("reset_lo",   LoOut, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed table; consecutive entries are issued back to back.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, hi, lo, lat);
         check({vecs[i].name, "_hi"},  hi, vecs[i].hi);
         check({vecs[i].name, "_lo"},  lo, vecs[i].lo);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(EXP_LAT));
      end

      // Start pulsed mid-operation with new operands: first result unaffected.
      run_op(OP_DIVU, 32'd1000, 32'd7, 10, hi, lo, lat);
      check("restart_hi",  hi, 32'd6);
      check("restart_lo",  lo, 32'd142);
      check("restart_lat", 32'(lat), 32'(EXP_LAT));
      run_op(OP_MULTU, 32'd6, 32'd7, 0, hi, lo, lat);
      check("b2b_hi",  hi, 32'd0);
      check("b2b_lo",  lo, 32'h2A);
      check("b2b_lat", 32'(lat), 32'(EXP_LAT));
      hlw_count = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (HiLoWrite) hlw_count++;
      end
      check("no_extra_hlw", 32'(hlw_count), 32'd0);

      // Random operations against the model.
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         model(op, a, b, ehi, elo);
         run_op(op, a, b, 0, hi, lo, lat);
         check($sformatf("rand%0d_op%0d_hi", i, op), hi, ehi);
         check($sformatf("rand%0d_op%0d_lo", i, op), lo, elo);
         check($sformatf("rand%0d_lat", i), 32'(lat), 32'(EXP_LAT));
      end

      // Known nonzero outputs, then reset at cycle 10 of a DIVU.
      run_op(OP_DIVU, 32'd100, 32'd7, 0, hi, lo, lat);
      check("pre_reset_hi", hi, 32'd2);
      check("pre_reset_lo", lo, 32'd14);
      @(negedge clk);
      Start = 1'b1; Operation = OP_DIVU; OperandA = 32'hFFFF; OperandB = 32'd3;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midreset_busy", {31'b0, Busy}, 32'd0);
      check("midreset_hi",   HiOut, 32'd0);
      check("midreset_lo",   LoOut, 32'd0);
      check("midreset_hlw",  {31'b0, HiLoWrite}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      hlw_count = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (HiLoWrite) hlw_count++;
      end
      check("midreset_no_hlw", 32'(hlw_count), 32'd0);

      // Unit recovers normally after the reset.
      run_op(OP_MULTU, 32'd6, 32'd7, 0, hi, lo, lat);
      check("post_reset_lo",  lo, 32'h2A);
      check("post_reset_lat", 32'(lat), 32'(EXP_LAT));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
